// File: rtl/dmem_if.sv
// Request/response bus between the MEM-stage requester and dmem_responder.
//   master : requester side (drives req_*, resp_ready)
//   slave  : responder side (drives req_ready, resp_*)
// Signals:
//   req_valid/req_ready   request handshake
//   req_wen               1 = store, 0 = load
//   req_addr              byte address, low three bits ignored
//   req_mask              byte strobes for stores, bit i = byte i
//   req_wdata             store data, lanes aligned to the 64-bit word
//   resp_valid/resp_ready response handshake
//   resp_rdata            load word, 0 for stores
//   resp_err              out-of-range flag
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [7:0]  req_mask;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_mask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_mask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the MEM-stage data port.
// Accepts one load/store at a time, commits stores (byte strobes) into a
// 64-bit word array at the accept edge, and returns a response LATENCY
// edges later, held until the requester takes it.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-high
//   bus  dmem_if.slave (request and response handshakes)
// Parameters: DEPTH_LOG2 (array words, log2), LATENCY (1..7), BASE_ADDR.
// Optional feature: define DMEM_RESP_ERR_EN to flag out-of-range requests
// with resp_err (no write, rdata 0); otherwise the index wraps and resp_err
// is tied low.
//
// state  | meaning
// IDLE   | ready for a request; accept edge commits store / captures load
// WAIT   | counting down the remaining latency
// RESP   | response pending; resp_valid raised one edge after entry,
//        | held until resp_valid & resp_ready
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [2:0] CNT_INIT = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  logic [2:0]            r_cnt;
  logic                  r_resp_valid;
  logic [63:0]           r_rdata;
  logic                  r_err;
  logic [63:0]           r_mem [DEPTH];

  logic [63:0]           w_offset;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_oor;
  logic                  w_accept;
  logic                  w_unused;

  assign w_offset = bus.req_addr - BASE_ADDR;
  assign w_idx    = w_offset[DEPTH_LOG2+2:3];

`ifdef DMEM_RESP_ERR_EN
  assign w_oor    = (w_offset >= (64'd8 << DEPTH_LOG2));
  assign w_unused = ^w_offset[2:0];
`else
  // Upper offset bits are dropped: out-of-range addresses wrap.
  assign w_oor    = 1'b0;
  assign w_unused = ^{w_offset[2:0], w_offset[63:DEPTH_LOG2+3]};
`endif

  // No commit on an edge where reset is held.
  assign w_accept = (r_state == S_IDLE) && bus.req_valid && !rst;

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  // Array has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_accept && bus.req_wen && !w_oor) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.req_mask[i]) begin
          r_mem[w_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 3'd0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 64'd0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (!bus.req_wen && !w_oor) begin
              r_rdata <= r_mem[w_idx];
            end else begin
              r_rdata <= 64'd0;
            end
            r_err <= w_oor;
            if (LATENCY == 1) begin
              r_state <= S_RESP;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_RESP: begin
          // resp_valid lags entry into RESP by one edge, which is what makes
          // the accept-to-valid distance exactly LATENCY edges.
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
          end else if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rdata      <= 64'd0;
            r_err        <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [7:0]  req_mask;
  logic [63:0] req_wdata;
  logic        resp_ready;

  int n_err = 0;
  int n_chk = 0;

  dmem_if b2 ();
  dmem_if b1 ();

  dmem_responder #(.LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  dmem_responder #(.LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  assign b2.req_valid  = req_valid & ~sel;
  assign b2.req_wen    = req_wen;
  assign b2.req_addr   = req_addr;
  assign b2.req_mask   = req_mask;
  assign b2.req_wdata  = req_wdata;
  assign b2.resp_ready = resp_ready & ~sel;
  assign b1.req_valid  = req_valid & sel;
  assign b1.req_wen    = req_wen;
  assign b1.req_addr   = req_addr;
  assign b1.req_mask   = req_mask;
  assign b1.req_wdata  = req_wdata;
  assign b1.resp_ready = resp_ready & sel;

  wire        req_ready  = sel ? b1.req_ready  : b2.req_ready;
  wire        resp_valid = sel ? b1.resp_valid : b2.resp_valid;
  wire [63:0] resp_rdata = sel ? b1.resp_rdata : b2.resp_rdata;
  wire        resp_err   = sel ? b1.resp_err   : b2.resp_err;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure accept-to-valid edges, return the response.
  // With hold=1 the response is left pending for the caller.
  task automatic transact(input logic wen, input logic [63:0] addr, input logic [7:0] mask,
                          input logic [63:0] wdata, input int exp_lat, input bit hold,
                          output logic [63:0] rdata, output logic err);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_wen    = wen;
    req_addr   = addr;
    req_mask   = mask;
    req_wdata  = wdata;
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = 64'd0;
    req_mask  = 8'd0;
    req_wdata = 64'd0;
    chk("busy_ready", req_ready, 0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, exp_lat);
    rdata = resp_rdata;
    err   = resp_err;
    if (!hold) begin
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("done_ready", req_ready, 1);
      chk("done_valid", resp_valid, 0);
      chk("done_rdata", resp_rdata, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    logic        er;

    sel        = 1'b0;
    req_valid  = 1'b0;
    req_wen    = 1'b0;
    req_addr   = 64'd0;
    req_mask   = 8'd0;
    req_wdata  = 64'd0;
    resp_ready = 1'b0;

    // 1. reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);

    // 2. full store then load
    transact(1'b1, 64'h8000_0008, 8'hFF, 64'h1122334455667788, 2, 1'b0, rd, er);
    chk("st_full_rdata", rd, 0);
    chk("st_full_err", er, 0);
    transact(1'b0, 64'h8000_0008, 8'h00, 64'd0, 2, 1'b0, rd, er);
    chk("ld_full_rdata", rd, 64'h1122334455667788);

    // 3. partial store
    transact(1'b1, 64'h8000_0008, 8'h0F, 64'hAAAAAAAABBBBBBBB, 2, 1'b0, rd, er);
    chk("st_part_rdata", rd, 0);
    transact(1'b0, 64'h8000_000F, 8'h00, 64'd0, 2, 1'b0, rd, er);
    chk("ld_part_rdata", rd, 64'h11223344BBBBBBBB);

    // mask 0 writes nothing
    transact(1'b1, 64'h8000_0008, 8'h00, 64'hFFFFFFFFFFFFFFFF, 2, 1'b0, rd, er);
    transact(1'b0, 64'h8000_0008, 8'h00, 64'd0, 2, 1'b0, rd, er);
    chk("ld_mask0_rdata", rd, 64'h11223344BBBBBBBB);

    // 4. response held while resp_ready low
    transact(1'b0, 64'h8000_0008, 8'h00, 64'd0, 2, 1'b1, rd, er);
    chk("hold_first_rdata", rd, 64'h11223344BBBBBBBB);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr  = 64'h8000_0010;
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, 64'h11223344BBBBBBBB);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid  = 1'b0;
    req_addr   = 64'd0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hold_done_ready", req_ready, 1);
    chk("hold_done_valid", resp_valid, 0);
    chk("hold_done_rdata", resp_rdata, 0);

    // 5. reset during WAIT after a store accept
    @(negedge clk);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_addr  = 64'h8000_0010;
    req_mask  = 8'hFF;
    req_wdata = 64'hCAFEF00D12345678;
    @(negedge clk);
    req_valid = 1'b0;
    req_wen   = 1'b0;
    chk("mid_wait_ready", req_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", req_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_valid", resp_valid, 0);
      chk("post_rst_ready", req_ready, 1);
    end
    transact(1'b0, 64'h8000_0010, 8'h00, 64'd0, 2, 1'b0, rd, er);
    chk("post_rst_ld", rd, 64'hCAFEF00D12345678);

    // 6. address below BASE_ADDR
    transact(1'b1, 64'h8000_7FF8, 8'hFF, 64'h0123456789ABCDEF, 2, 1'b0, rd, er);
    transact(1'b1, 64'h7FFF_FFF8, 8'hFF, 64'hFEDCBA9876543210, 2, 1'b0, rd, er);
    chk("oor_st_rdata", rd, 0);
`ifdef DMEM_RESP_ERR_EN
    chk("oor_st_err", er, 1);
    transact(1'b0, 64'h8000_7FF8, 8'h00, 64'd0, 2, 1'b0, rd, er);
    chk("oor_unchanged", rd, 64'h0123456789ABCDEF);
    chk("oor_ld_ok_err", er, 0);
    transact(1'b0, 64'h8000_8000, 8'h00, 64'd0, 2, 1'b0, rd, er);
    chk("oor_ld_rdata", rd, 0);
    chk("oor_ld_err", er, 1);
`else
    chk("wrap_st_err", er, 0);
    transact(1'b0, 64'h8000_7FF8, 8'h00, 64'd0, 2, 1'b0, rd, er);
    chk("wrap_idx4095", rd, 64'hFEDCBA9876543210);
`endif

    // 7. LATENCY=1 instance
    sel = 1'b1;
    @(negedge clk);
    chk("l1_idle_ready", req_ready, 1);
    transact(1'b1, 64'h8000_0020, 8'hFF, 64'h5555AAAA5555AAAA, 1, 1'b0, rd, er);
    chk("l1_st_rdata", rd, 0);
    transact(1'b0, 64'h8000_0020, 8'h00, 64'd0, 1, 1'b0, rd, er);
    chk("l1_ld_rdata", rd, 64'h5555AAAA5555AAAA);
    chk("l1_ld_err", er, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
